// File: rtl/layer2_result_sched_if.sv
// Producer/consumer handshake bundle for the layer-2 result scheduler.
// master = producer + layer-3 fetch side, slave = scheduler.
interface layer2_result_sched_if #(
    parameter int DATA_W = 128
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_req;
    logic [15:0]       rd_row;
    logic [15:0]       rd_col;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_valid, wr_data, rd_req, rd_row, rd_col,
        input  wr_ready, rd_gnt, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_req, rd_row, rd_col,
        output wr_ready, rd_gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/layer2_result_sched.sv
// Sequences the ROWSxCOLS layer-2 result memory: raster-order fill, gated reads, frame release.
// Define L2_RAW_CHECK_EN to allow reads of already-written words during FILL.
module layer2_result_sched #(
    parameter int ROWS   = 30,
    parameter int COLS   = 30,
    parameter int DATA_W = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    // consumer done with the frame (`release` is a reserved word)
    input  logic                frame_release,
    layer2_result_sched_if.slave bus,
    output logic                mem_save_enable,
    output logic [15:0]         mem_save_row_addr,
    output logic [15:0]         mem_save_col_addr,
    output logic [DATA_W-1:0]   mem_store_data,
    output logic                mem_read_signal,
    output logic [15:0]         mem_read_row_addr,
    output logic [15:0]         mem_read_col_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                frame_full,
    output logic                busy
);
    localparam int TOTAL = ROWS * COLS;
    localparam int CW    = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [15:0]   wr_row, wr_col;
    logic [CW-1:0] wr_count;
    logic          wr_fire, last_wr, in_range, fill_ok, legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FILL;
            FILL:    if (wr_fire && last_wr) state_nxt = DRAIN;
            DRAIN:   if (frame_release) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.wr_ready = (state == FILL);
    assign wr_fire      = bus.wr_valid & bus.wr_ready;
    assign last_wr      = (wr_count == CW'(TOTAL - 1));

    // Row wraps back to 0 on the final write; the address is unused in DRAIN anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_row   <= '0;
            wr_col   <= '0;
            wr_count <= '0;
        end else if (state == IDLE && start) begin
            wr_row   <= '0;
            wr_col   <= '0;
            wr_count <= '0;
        end else if (wr_fire) begin
            wr_count <= wr_count + CW'(1);
            if (wr_col == 16'(COLS - 1)) begin
                wr_col <= '0;
                wr_row <= (wr_row == 16'(ROWS - 1)) ? 16'd0 : wr_row + 16'd1;
            end else begin
                wr_col <= wr_col + 16'd1;
            end
        end
    end

    assign mem_save_enable   = wr_fire;
    assign mem_save_row_addr = wr_row;
    assign mem_save_col_addr = wr_col;
    assign mem_store_data    = bus.wr_data;
    assign frame_full        = (wr_count == CW'(TOTAL));
    assign busy              = (state != IDLE);

    assign in_range = (bus.rd_row < 16'(ROWS)) && (bus.rd_col < 16'(COLS));

`ifdef L2_RAW_CHECK_EN
    // Compared against the count before this cycle's write, so a same-cycle
    // write to the requested word is never forwarded.
    logic [31:0] idx;
    assign idx     = {16'd0, bus.rd_row} * 32'(COLS) + {16'd0, bus.rd_col};
    assign fill_ok = in_range && (idx < 32'(wr_count));
`else
    assign fill_ok = 1'b0;
`endif

    always_comb begin
        legal = 1'b0;
        case (state)
            FILL:    legal = fill_ok;
            DRAIN:   legal = in_range;
            default: legal = 1'b0;
        endcase
    end

    assign bus.rd_gnt        = bus.rd_req & legal;
    assign mem_read_signal   = bus.rd_gnt;
    assign mem_read_row_addr = bus.rd_row;
    assign mem_read_col_addr = bus.rd_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= bus.rd_gnt;
            if (bus.rd_gnt) bus.rd_data <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_layer2_result_sched.sv
// Directed bench for layer2_result_sched with a behavioural 30x30 result memory.
module tb_layer2_result_sched;
`ifdef L2_RAW_CHECK_EN
    localparam bit RAW = 1'b1;
`else
    localparam bit RAW = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         frame_release;
    logic         mem_save_enable;
    logic [15:0]  mem_save_row_addr, mem_save_col_addr;
    logic [127:0] mem_store_data;
    logic         mem_read_signal;
    logic [15:0]  mem_read_row_addr, mem_read_col_addr;
    logic [127:0] mem_rdata;
    logic         frame_full, busy;
    logic [127:0] mem [0:899];

    int n_chk  = 0;
    int n_fail = 0;

    layer2_result_sched_if #(.DATA_W(128)) bus ();

    layer2_result_sched #(.ROWS(30), .COLS(30), .DATA_W(128)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .frame_release     (frame_release),
        .bus               (bus),
        .mem_save_enable   (mem_save_enable),
        .mem_save_row_addr (mem_save_row_addr),
        .mem_save_col_addr (mem_save_col_addr),
        .mem_store_data    (mem_store_data),
        .mem_read_signal   (mem_read_signal),
        .mem_read_row_addr (mem_read_row_addr),
        .mem_read_col_addr (mem_read_col_addr),
        .mem_rdata         (mem_rdata),
        .frame_full        (frame_full),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_save_enable && mem_save_row_addr < 30 && mem_save_col_addr < 30)
            mem[mem_save_row_addr * 30 + mem_save_col_addr] <= mem_store_data;

    always_comb begin
        mem_rdata = '0;
        if (mem_read_row_addr < 30 && mem_read_col_addr < 30)
            mem_rdata = mem[mem_read_row_addr * 30 + mem_read_col_addr];
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_set(input logic req, input int r, input int c);
        bus.rd_req = req;
        bus.rd_row = 16'(r);
        bus.rd_col = 16'(c);
    endtask

    initial begin
        for (int k = 0; k < 900; k++) mem[k] = '0;
        rst = 1'b1; start = 1'b0; frame_release = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_data = '0;
        rd_set(1'b0, 0, 0);
        #1;
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_rd_gnt", bus.rd_gnt, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_frame_full", frame_full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_save_en", mem_save_enable, 0);
        chk("rst_save_row", mem_save_row_addr, 0);
        chk("rst_save_col", mem_save_col_addr, 0);
        tick(); tick();
        rst = 1'b0;
        // request in IDLE is never granted
        rd_set(1'b1, 0, 0); #1;
        chk("idle_rd_gnt", bus.rd_gnt, 0);
        rd_set(1'b0, 0, 0);
        tick();

        start = 1'b1; tick(); start = 1'b0;
        chk("fill_busy", busy, 1);
        chk("fill_wr_ready", bus.wr_ready, 1);

        for (int i = 0; i < 900; i++) begin
            if (i == 31) begin
                bus.wr_valid = 1'b0;
                rd_set(1'b1, 1, 0); #1;
                chk("raw_1_0_gnt", bus.rd_gnt, RAW);
                tick();
                chk("raw_1_0_valid", bus.rd_valid, RAW);
                chk("raw_1_0_data", bus.rd_data, RAW ? 30 : 0);
                rd_set(1'b1, 1, 1); #1;
                chk("raw_1_1_early_gnt", bus.rd_gnt, 0);
                tick();
                chk("raw_1_1_early_valid", bus.rd_valid, 0);
                bus.wr_valid = 1'b1; bus.wr_data = 128'(i); #1;
                chk("raw_same_cycle_gnt", bus.rd_gnt, 0);
                chk("raw_same_cycle_save_row", mem_save_row_addr, 1);
                chk("raw_same_cycle_save_col", mem_save_col_addr, 1);
                chk("raw_same_cycle_save_en", mem_save_enable, 1);
                tick();
                bus.wr_valid = 1'b0; #1;
                chk("raw_after_write_gnt", bus.rd_gnt, RAW);
                tick();
                chk("raw_after_write_valid", bus.rd_valid, RAW);
                chk("raw_after_write_data", bus.rd_data, RAW ? 31 : 0);
                rd_set(1'b0, 0, 0);
                continue;
            end
            bus.wr_valid  = 1'b1;
            bus.wr_data   = 128'(i);
            frame_release = (i == 100);
            start         = (i == 200);
            #1;
            chk("fill_save_row", mem_save_row_addr, 128'(i / 30));
            chk("fill_save_col", mem_save_col_addr, 128'(i % 30));
            chk("fill_save_en", mem_save_enable, 1);
            chk("fill_store_data", mem_store_data, 128'(i));
            if (i == 899) chk("pre_last_frame_full", frame_full, 0);
            tick();
            if (i == 100) chk("release_in_fill_ignored", bus.wr_ready, 1);
            frame_release = 1'b0;
            start         = 1'b0;
        end
        bus.wr_valid = 1'b0;
        chk("drain_frame_full", frame_full, 1);
        chk("drain_wr_ready", bus.wr_ready, 0);
        chk("drain_busy", busy, 1);
        chk("drain_save_en", mem_save_enable, 0);

        // back-to-back grants in DRAIN
        rd_set(1'b1, 12, 7); #1;
        chk("drain_12_7_gnt", bus.rd_gnt, 1);
        chk("drain_12_7_mem_rd", mem_read_signal, 1);
        tick();
        chk("drain_12_7_valid", bus.rd_valid, 1);
        chk("drain_12_7_data", bus.rd_data, 367);
        rd_set(1'b1, 1, 1); #1;
        chk("drain_1_1_gnt", bus.rd_gnt, 1);
        tick();
        chk("drain_1_1_data", bus.rd_data, 31);
        rd_set(1'b1, 29, 29); tick();
        chk("drain_29_29_valid", bus.rd_valid, 1);
        chk("drain_29_29_data", bus.rd_data, 899);
        rd_set(1'b1, 30, 0); #1;
        chk("oor_row_gnt", bus.rd_gnt, 0);
        tick();
        chk("oor_row_valid", bus.rd_valid, 0);
        rd_set(1'b1, 0, 30); #1;
        chk("oor_col_gnt", bus.rd_gnt, 0);
        tick();
        chk("oor_col_valid", bus.rd_valid, 0);
        chk("oor_data_held", bus.rd_data, 899);
        rd_set(1'b0, 0, 0);

        frame_release = 1'b1; tick(); frame_release = 1'b0;
        chk("release_busy", busy, 0);
        chk("release_wr_ready", bus.wr_ready, 0);
        chk("release_frame_full_kept", frame_full, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_frame_full", frame_full, 0);
        chk("restart_busy", busy, 1);

        // refill to the midpoint, then reset with a read in flight
        for (int i = 0; i < 450; i++) begin
            bus.wr_valid = 1'b1; bus.wr_data = 128'(i + 1000);
            tick();
        end
        bus.wr_data = 128'(1450);
        rd_set(1'b1, 0, 0); #1;
        chk("mid_save_row", mem_save_row_addr, 15);
        chk("mid_rd_gnt", bus.rd_gnt, RAW);
        rst = 1'b1; #1;
        chk("arst_rd_gnt", bus.rd_gnt, 0);
        chk("arst_rd_valid", bus.rd_valid, 0);
        chk("arst_rd_data", bus.rd_data, 0);
        chk("arst_wr_ready", bus.wr_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_save_en", mem_save_enable, 0);
        chk("arst_save_row", mem_save_row_addr, 0);
        tick();
        chk("arst_valid_dropped", bus.rd_valid, 0);
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        rd_set(1'b0, 0, 0);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_data = 128'(7); #1;
        chk("refill_save_row", mem_save_row_addr, 0);
        chk("refill_save_col", mem_save_col_addr, 0);
        chk("refill_save_en", mem_save_enable, 1);
        tick();
        bus.wr_valid = 1'b0; #1;
        chk("refill_next_col", mem_save_col_addr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
